display_scan: RTL and testbench
===============================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 SHALL provide parameter PRESCALE, default 100000, clock cycles per digit slot; legal range 2..2^24-1.
REQ-002 SHALL provide port CLK  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL provide port RST  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL provide port EN  input  1  display enable; low blanks all digits.
REQ-005 SHALL provide port VALUE  input  32  eight hex nibbles; VALUE[4i+3:4i] is digit i, digit 0 rightmost.
REQ-006 SHALL provide port DP_MASK  input  8  bit i = 1 lights decimal point of digit i.
REQ-007 SHALL provide port AN  output  8  digit anodes, active-low, at most one bit low.
REQ-008 SHALL provide port DIGIT  output  4  nibble of current digit, wired to hex-to-7seg decoder IN.
REQ-009 SHALL provide port DP  output  1  active-low decimal point, wired to decoder DP.
REQ-010 SHALL provide port FRAME  output  1  one-cycle pulse when a new frame snapshot is taken.

Function
REQ-011 SHALL count prescaler 0..PRESCALE-1 and wrap; a tick is the cycle with count = PRESCALE-1.
REQ-012 SHALL hold 3-bit digit index; on each tick index increments modulo 8 (7 -> 0).
REQ-013 SHALL on the tick where index wraps 7 -> 0 load shadow registers from VALUE and DP_MASK and assert FRAME for that one edge.
REQ-014 SHALL source DIGIT and DP only from the shadow registers; VALUE/DP_MASK changes mid-frame do not affect displayed data until the next frame.
REQ-015 SHALL on the edge following a tick register DIGIT = shadow nibble of new index, DP = ~shadow DP bit of new index, AN = 8'hFF (ghosting guard, one cycle).
REQ-016 SHALL on the next edge drive AN with bit [index] low, all others high, holding it until the next tick's guard; each digit is lit PRESCALE-1 cycles per slot.
REQ-017 SHALL, when the new index is 0, use the just-loaded snapshot in the same edge (no one-frame lag).
REQ-018 SHALL, when EN = 0, register AN = 8'hFF on the next edge; prescaler, index, shadow, FRAME continue running.
REQ-019 SHALL, when EN returns to 1 mid-slot, resume the one-cold AN for the current index on the next edge.
REQ-020 SHALL have all outputs registered; no combinational path from inputs to outputs.

Reset
REQ-021 SHALL on RST = 1 set prescaler 0, index 7, shadow VALUE 0, shadow DP_MASK 0, AN 8'hFF, DIGIT 4'h0, DP 1, FRAME 0.
REQ-022 SHALL let RST override EN and any tick in the same cycle; reset mid-slot or mid-frame discards partial state.
REQ-023 SHALL after RST release produce first tick at count PRESCALE-1, wrapping index 7 -> 0 and taking the first snapshot.

Configuration
REQ-024 SHALL compile leading-zero blanking when macro DISPLAY_SCAN_LZB_EN is defined.
REQ-025 SHALL, with DISPLAY_SCAN_LZB_EN, keep AN[i] high for digit i (7..1) when shadow nibbles i..7 are all zero and shadow DP_MASK[i] = 0; digit 0 never blanked.
REQ-026 SHALL, without DISPLAY_SCAN_LZB_EN, light all eight digits in turn regardless of value.

Verification (PRESCALE = 4)
REQ-027 SHALL check: RST then VALUE=32'h12345678, DP_MASK=0, EN=1 -> FRAME pulse at cycle 4, AN=FF with DIGIT=8, next cycle AN=8'hFE for 3 cycles; then DIGIT=7, AN=8'hFD; sequence repeats every 32 cycles.
REQ-028 SHALL check: change VALUE to 32'hFFFFFFFF while index = 3 -> digits 4..7 still show 4,3,2,1; DIGIT=F only after the next FRAME.
REQ-029 SHALL check: DP_MASK=8'h04 -> DP=0 only while index = 2 (AN=8'hFB), DP=1 otherwise.
REQ-030 SHALL check: EN=0 for 10 cycles -> AN=8'hFF from next edge, DIGIT keeps cycling, FRAME still pulses; EN=1 -> correct AN next edge.
REQ-031 SHALL check with DISPLAY_SCAN_LZB_EN: VALUE=32'h000000A0 -> AN bits 7..2 never low, digits 1 (A) and 0 (0) lit; without macro all eight AN bits go low in turn.
REQ-032 SHALL check: RST asserted mid-slot with AN=8'hF7 -> next edge all outputs at REQ-021 values; first FRAME 4 cycles after release.

Source files
------------

// File: rtl/display_scan.sv
// Eight-digit multiplexed seven-segment scanner with per-frame snapshot.
// Optional leading-zero blanking when DISPLAY_SCAN_LZB_EN is defined.
module display_scan #(
  parameter int unsigned PRESCALE = 100000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [31:0] VALUE,
  input  logic [7:0]  DP_MASK,
  output logic [7:0]  AN,
  output logic [3:0]  DIGIT,
  output logic        DP,
  output logic        FRAME
);

  localparam int CW = 24;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [2:0]    nidx;
  logic [31:0]   sval;
  logic [7:0]    smask;
  logic          live;
  logic          tick;
  logic          wrap;
  logic [31:0]   src_val;
  logic [7:0]    src_mask;
  logic [7:0]    blank;
  logic [7:0]    cold;

  assign tick     = (cnt == LAST);
  assign wrap     = tick && (idx == 3'd7);
  assign nidx     = idx + 3'd1;
  assign src_val  = wrap ? VALUE : sval;
  assign src_mask = wrap ? DP_MASK : smask;

  // Digits to keep dark: leading zeros without a decimal point
  always_comb begin
    blank = '0;
`ifdef DISPLAY_SCAN_LZB_EN
    for (int i = 1; i < 8; i++) begin
      blank[i] = ((sval >> (4 * i)) == 32'd0) && !smask[i];
    end
`endif
  end

  // One-cold anode pattern for the current digit
  always_comb begin
    cold = ~(8'd1 << idx) | blank;
  end

  // Prescaler, digit index, snapshot and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt   <= '0;
      idx   <= 3'd7;
      sval  <= '0;
      smask <= '0;
      live  <= 1'b0;
      AN    <= 8'hFF;
      DIGIT <= 4'h0;
      DP    <= 1'b1;
      FRAME <= 1'b0;
    end else begin
      cnt   <= tick ? '0 : cnt + 1'b1;
      FRAME <= wrap;
      if (tick) begin
        idx   <= nidx;
        live  <= 1'b1;
        AN    <= 8'hFF;
        DIGIT <= src_val[{nidx, 2'b00} +: 4];
        DP    <= ~src_mask[nidx];
        if (wrap) begin
          sval  <= VALUE;
          smask <= DP_MASK;
        end
      end else begin
        AN <= (EN && live) ? cold : 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan at PRESCALE = 4.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_display_scan;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic [31:0] VALUE;
  logic [7:0]  DP_MASK;
  logic [7:0]  AN;
  logic [3:0]  DIGIT;
  logic        DP;
  logic        FRAME;

  always #5 CLK = ~CLK;

  display_scan #(.PRESCALE(4)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (EN),
    .VALUE  (VALUE),
    .DP_MASK(DP_MASK),
    .AN     (AN),
    .DIGIT  (DIGIT),
    .DP     (DP),
    .FRAME  (FRAME)
  );

  typedef struct packed {
    logic [7:0] an;
    logic [3:0] dig;
    logic       dp;
    logic       fr;
  } exp_t;

  exp_t  q[$];
  string qn[$];
  int    n_chk = 0;
  int    n_fail = 0;

  int          k;
  logic [31:0] snap;
  logic [7:0]  msk;
  logic [3:0]  mdig;
  logic        mdp;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req,
               $time);
    end
  endtask

  // Monitor: one expectation per clock edge
  always @(negedge CLK) begin
    exp_t  e;
    string nm;
    if (q.size() > 0) begin
      e  = q.pop_front();
      nm = qn.pop_front();
      chk({nm, ".AN"},    32'(AN),    32'(e.an));
      chk({nm, ".DIGIT"}, 32'(DIGIT), 32'(e.dig));
      chk({nm, ".DP"},    32'(DP),    32'(e.dp));
      chk({nm, ".FRAME"}, 32'(FRAME), 32'(e.fr));
    end
  end

  function automatic int cur_idx();
    int m;
    m = k / 4;
    return (m == 0) ? 7 : (m + 7) % 8;
  endfunction

  // Time-indexed reference: slot m = k/4, phase = k%4
  function automatic exp_t model();
    exp_t e;
    int   m;
    int   ph;
    int   ix;
    if (RST) begin
      k = 0; snap = 0; msk = 0; mdig = 0; mdp = 1'b1;
      e = '{8'hFF, 4'h0, 1'b1, 1'b0};
      return e;
    end
    k++;
    m  = k / 4;
    ph = k % 4;
    ix = (m + 7) % 8;
    if (m == 0) begin
      e = '{8'hFF, mdig, mdp, 1'b0};
    end else if (ph == 0) begin
      if (ix == 0) begin
        snap = VALUE;
        msk  = DP_MASK;
      end
      mdig = snap[4*ix +: 4];
      mdp  = ~msk[ix];
      e = '{8'hFF, mdig, mdp, ix == 0};
    end else begin
      e.an = EN ? ~(8'd1 << ix) : 8'hFF;
`ifdef DISPLAY_SCAN_LZB_EN
      if (ix > 0 && (snap >> (4 * ix)) == 0 && !msk[ix])
        e.an = 8'hFF;
`endif
      e.dig = mdig;
      e.dp  = mdp;
      e.fr  = 1'b0;
    end
    return e;
  endfunction

  task automatic step(input string nm);
    exp_t e;
    @(posedge CLK);
    e = model();
    q.push_back(e);
    qn.push_back(nm);
    #1;
  endtask

  task automatic step_hand(input string nm, input exp_t h);
    exp_t e;
    @(posedge CLK);
    e = model();
    q.push_back(h);
    qn.push_back(nm);
    #1;
  endtask

  task automatic run(input string nm, input int n);
    for (int i = 0; i < n; i++) step(nm);
  endtask

  task automatic seek(input string nm, input int ix, input int ph);
    int i;
    i = 0;
    while (!(k >= 4 && cur_idx() == ix && k % 4 == ph) && i < 64) begin
      step(nm);
      i++;
    end
    n_chk++;
    if (i >= 64) begin
      n_fail++;
      $display("FAIL %s.seek: got timeout expected idx %0d", nm, ix);
    end
  endtask

  initial begin
    exp_t hand [9];
    hand[0] = '{8'hFF, 4'h0, 1'b1, 1'b0};
    hand[1] = '{8'hFF, 4'h0, 1'b1, 1'b0};
    hand[2] = '{8'hFF, 4'h0, 1'b1, 1'b0};
    hand[3] = '{8'hFF, 4'h8, 1'b1, 1'b1};
    hand[4] = '{8'hFE, 4'h8, 1'b1, 1'b0};
    hand[5] = '{8'hFE, 4'h8, 1'b1, 1'b0};
    hand[6] = '{8'hFE, 4'h8, 1'b1, 1'b0};
    hand[7] = '{8'hFF, 4'h7, 1'b1, 1'b0};
    hand[8] = '{8'hFD, 4'h7, 1'b1, 1'b0};
    k = 0; snap = 0; msk = 0; mdig = 0; mdp = 1'b1;

    RST = 1'b1; EN = 1'b1; VALUE = 32'h12345678; DP_MASK = 8'h00;
    #1;
    run("reset", 2);
    RST = 1'b0;
    for (int i = 0; i < 9; i++) step_hand("first_frame", hand[i]);
    run("scan", 40);

    seek("freeze", 3, 1);
    VALUE = 32'hFFFFFFFF;
    run("freeze", 48);

    DP_MASK = 8'h04;
    run("dp", 40);
    DP_MASK = 8'h00;

    seek("en_off", 5, 2);
    EN = 1'b0;
    run("en_off", 10);
    EN = 1'b1;
    run("en_on", 12);

    VALUE = 32'h000000A0;
    run("lzb", 72);

    VALUE = 32'h12345678;
    run("restore", 40);
    seek("rst_mid", 3, 2);
    RST = 1'b1;
    step("rst_mid");
    RST = 1'b0;
    run("rst_rel", 12);

    @(negedge CLK);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
